// File: rtl/spi_register_writer_pkg.sv
// Shared definitions for the SPI register writer: word width, counter
// widths and the transmit FSM state encoding.
package spi_register_writer_pkg;

  localparam int SPI_WORD_WIDTH = 32;
  localparam int SPI_BIT_CNT_W  = 5;
  localparam int SPI_PHASE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_GAP      = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous show-ahead word queue.
// The head word is always visible on o_data while o_empty is low; a pop
// advances to the next entry on the following edge.
// A push while full is dropped, even when a pop happens in the same cycle.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset (empties the queue)
//   i_push   write i_data at the tail (ignored when full)
//   i_data   word to enqueue
//   i_pop    advance the head (ignored when empty)
//   o_data   current head word
//   o_full   no free entry
//   o_empty  no stored entry
module spi_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Fullness is judged before any same-cycle pop, so a full queue never
  // accepts a word.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_register_writer.sv
// Serialises queued 32-bit register words onto a 3-wire SPI bus
// (SCLK / DATA / LATCH) for a PLL, MSB first, one latch pulse per word.
//
// Ports:
//   ipClk        system clock, rising edge
//   ipReset      synchronous active-high reset; aborts any word in flight
//   ipWord       register word to send (control bits included)
//   ipValid      ipWord valid; accepted when opReady is high
//   opReady      queue has room this cycle
//   opBusy       queue non-empty or a word in flight
//   opSPI_SClk   serial clock, idles low
//   opSPI_Data   serial data, only changes while SCLK is low
//   opSPI_Latch  load-enable pulse after the 32nd bit
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | nothing to send, all SPI outputs low
// LOAD      | head word held in shift register, bit 31 on DATA
// SHIFT_LO  | SCLK low for CLK_DIV cycles, DATA stable
// SHIFT_HI  | SCLK high for CLK_DIV cycles; exit shifts to next bit
// LATCH     | LATCH high for LATCH_CYCLES cycles, SCLK and DATA low
// GAP       | all outputs low for CLK_DIV cycles before the next word
module spi_register_writer
  import spi_register_writer_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                      ipClk,
  input  logic                      ipReset,
  input  logic [SPI_WORD_WIDTH-1:0] ipWord,
  input  logic                      ipValid,
  output logic                      opReady,
  output logic                      opBusy,
  output logic                      opSPI_SClk,
  output logic                      opSPI_Data,
  output logic                      opSPI_Latch
);

  localparam logic [SPI_PHASE_W-1:0]   C_DIV_M1   = SPI_PHASE_W'(CLK_DIV - 1);
  localparam logic [SPI_PHASE_W-1:0]   C_LATCH_M1 = SPI_PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] C_LAST_BIT = SPI_BIT_CNT_W'(SPI_WORD_WIDTH - 1);

  spi_state_t                r_state;
  logic [SPI_WORD_WIDTH-1:0] r_shift;
  logic [SPI_BIT_CNT_W-1:0]  r_bit;
  logic [SPI_PHASE_W-1:0]    r_phase;
  logic                      r_sclk;
  logic                      r_latch;

  logic [SPI_WORD_WIDTH-1:0] w_fifo_data;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_phase_done;
  logic                      w_load;

  assign w_phase_done = (r_phase == '0);
  // A word is popped on the same edge the FSM enters LOAD, either from IDLE
  // or at the end of GAP, so the shift register holds it during LOAD.
  assign w_load = !w_fifo_empty &&
                  ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_phase_done));

  spi_word_fifo #(
    .WIDTH (SPI_WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (ipClk),
    .i_reset (ipReset),
    .i_push  (ipValid),
    .i_data  (ipWord),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_phase <= '0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_LOAD;
            r_shift <= w_fifo_data;
          end
        end

        ST_LOAD: begin
          r_state <= ST_SHIFT_LO;
          r_phase <= C_DIV_M1;
        end

        ST_SHIFT_LO: begin
          if (w_phase_done) begin
            r_state <= ST_SHIFT_HI;
            r_phase <= C_DIV_M1;
            r_sclk  <= 1'b1;
          end else begin
            r_phase <= r_phase - SPI_PHASE_W'(1);
          end
        end

        ST_SHIFT_HI: begin
          if (w_phase_done) begin
            r_sclk  <= 1'b0;
            // Zero fill: after the 32nd shift the register is all zeros, which
            // is what keeps DATA low through LATCH, GAP and IDLE.
            r_shift <= {r_shift[SPI_WORD_WIDTH-2:0], 1'b0};
            r_bit   <= r_bit + SPI_BIT_CNT_W'(1);
            if (r_bit == C_LAST_BIT) begin
              r_state <= ST_LATCH;
              r_phase <= C_LATCH_M1;
              r_latch <= 1'b1;
            end else begin
              r_state <= ST_SHIFT_LO;
              r_phase <= C_DIV_M1;
            end
          end else begin
            r_phase <= r_phase - SPI_PHASE_W'(1);
          end
        end

        ST_LATCH: begin
          if (w_phase_done) begin
            r_state <= ST_GAP;
            r_phase <= C_DIV_M1;
            r_latch <= 1'b0;
          end else begin
            r_phase <= r_phase - SPI_PHASE_W'(1);
          end
        end

        ST_GAP: begin
          if (w_phase_done) begin
            if (w_load) begin
              r_state <= ST_LOAD;
              r_shift <= w_fifo_data;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_phase <= r_phase - SPI_PHASE_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_sclk  <= 1'b0;
          r_latch <= 1'b0;
        end
      endcase
    end
  end

  assign opSPI_SClk  = r_sclk;
  assign opSPI_Data  = r_shift[SPI_WORD_WIDTH-1];
  assign opSPI_Latch = r_latch;
  assign opReady     = !w_fifo_full;
  assign opBusy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_spi_register_writer.sv
module tb_spi_register_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int load_cyc = 0;

  // default-parameter instance
  logic        rst = 1'b1;
  logic [31:0] word = '0;
  logic        valid = 1'b0;
  logic        ready, busy, sclk, sdata, latch;

  spi_register_writer u_dut (
    .ipClk       (clk),
    .ipReset     (rst),
    .ipWord      (word),
    .ipValid     (valid),
    .opReady     (ready),
    .opBusy      (busy),
    .opSPI_SClk  (sclk),
    .opSPI_Data  (sdata),
    .opSPI_Latch (latch)
  );

  // fastest-timing instance
  logic        f_rst = 1'b1;
  logic [31:0] f_word = '0;
  logic        f_valid = 1'b0;
  logic        f_ready, f_busy, f_sclk, f_sdata, f_latch;

  spi_register_writer #(
    .CLK_DIV      (1),
    .LATCH_CYCLES (1),
    .FIFO_DEPTH   (8)
  ) u_dut_fast (
    .ipClk       (clk),
    .ipReset     (f_rst),
    .ipWord      (f_word),
    .ipValid     (f_valid),
    .opReady     (f_ready),
    .opBusy      (f_busy),
    .opSPI_SClk  (f_sclk),
    .opSPI_Data  (f_sdata),
    .opSPI_Latch (f_latch)
  );

  // wire monitors: capture bits on SCLK rise, words on LATCH rise
  logic        m_sclk = 1'b0, m_data = 1'b0, m_latch = 1'b0;
  logic [31:0] m_cap = '0;
  int          m_nbits = 0, m_latch_len = 0, m_latch_pulses = 0, m_viol = 0;
  logic [31:0] rx_q[$];
  int          rx_bits_q[$];
  int          latch_len_q[$];

  always @(negedge clk) begin
    if (rst) m_nbits = 0;
    if (sclk && !m_sclk) begin
      m_cap = {m_cap[30:0], sdata};
      m_nbits++;
    end
    if (sclk && (sdata !== m_data)) m_viol++;
    if (sclk && latch) m_viol++;
    if (latch && !m_latch) begin
      rx_q.push_back(m_cap);
      rx_bits_q.push_back(m_nbits);
      m_nbits = 0;
      m_latch_len = 0;
      m_latch_pulses++;
    end
    if (latch) m_latch_len++;
    if (!latch && m_latch) latch_len_q.push_back(m_latch_len);
    m_sclk = sclk;
    m_data = sdata;
    m_latch = latch;
  end

  logic        fm_sclk = 1'b0, fm_data = 1'b0, fm_latch = 1'b0;
  logic [31:0] fm_cap = '0;
  int          fm_viol = 0;
  logic [31:0] f_rx_q[$];

  always @(negedge clk) begin
    if (f_sclk && !fm_sclk) fm_cap = {fm_cap[30:0], f_sdata};
    if (f_sclk && (f_sdata !== fm_data)) fm_viol++;
    if (f_sclk && f_latch) fm_viol++;
    if (f_latch && !fm_latch) f_rx_q.push_back(fm_cap);
    fm_sclk = f_sclk;
    fm_data = f_sdata;
    fm_latch = f_latch;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_rst = 1'b1;
    valid = 1'b1; word = 32'hDEAD_BEEF;
    repeat (3) tick();
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", sdata); end
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", latch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    valid = 1'b0; rst = 1'b0; f_rst = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_push_ignored: busy got %b expected 0", busy); end
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL reset_fast_busy: got %b expected 0", f_busy); end
  endtask

  task automatic test_single_word();
    int n;
    rx_q.delete(); rx_bits_q.delete(); latch_len_q.delete();
    word = 32'h8000_0007; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
    checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL single_idle_data: got %b expected 0", sdata); end
    tick();
    checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL single_load_data: got %b expected 1", sdata); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL single_load_sclk: got %b expected 0", sclk); end
    n = 0;
    while (busy === 1'b1 && n < 1000) begin tick(); n++; end
    checks++; if (n != 265) begin errors++; $display("FAIL single_word_cycles: got %0d expected 265", n); end
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_word_count: got %0d expected 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== 32'h8000_0007) begin errors++; $display("FAIL single_word_value: got %h expected 80000007", rx_q[0]); end
      checks++; if (rx_bits_q[0] != 32) begin errors++; $display("FAIL single_word_bits: got %0d expected 32", rx_bits_q[0]); end
    end
    checks++; if (latch_len_q.size() != 1) begin errors++; $display("FAIL single_latch_pulses: got %0d expected 1", latch_len_q.size()); end
    if (latch_len_q.size() > 0) begin
      checks++; if (latch_len_q[0] != 4) begin errors++; $display("FAIL single_latch_width: got %0d expected 4", latch_len_q[0]); end
    end
  endtask

  logic [31:0] w0 = 32'h1234_5678;
  logic [31:0] burst [9] = '{32'h9111_0001, 32'h2222_0002, 32'h3333_0003, 32'hC444_0004,
                             32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'hF888_0008,
                             32'h0999_0009};

  task automatic test_back_to_back();
    logic exp_rdy;
    rx_q.delete(); rx_bits_q.delete(); latch_len_q.delete();
    word = w0; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    load_cyc = cyc;
    repeat (20) tick();
    for (int i = 0; i < 9; i++) begin
      word = burst[i]; valid = 1'b1;
      exp_rdy = (i < 8) ? 1'b1 : 1'b0;
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL burst_ready_%0d: got %b expected %b", i, ready, exp_rdy); end
      tick();
    end
    valid = 1'b0;
    repeat (5) tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL burst_ready_held_low: got %b expected 0", ready); end
  endtask

  task automatic test_full_push_pop();
    int n;
    while (cyc < load_cyc + 264) tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready_before: got %b expected 0", ready); end
    word = 32'hBAD0_0BAD; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fullpop_dropped_ready: got %b expected 1", ready); end
    checks++; if (sdata !== burst[0][31]) begin errors++; $display("FAIL fullpop_next_load_data: got %b expected %b", sdata, burst[0][31]); end
    n = 0;
    while (busy === 1'b1 && n < 4000) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fullpop_drain_timeout: busy got %b expected 0", busy); end
    checks++; if (rx_q.size() != 9) begin errors++; $display("FAIL fullpop_word_count: got %0d expected 9", rx_q.size()); end
    if (rx_q.size() == 9) begin
      checks++; if (rx_q[0] !== w0) begin errors++; $display("FAIL order_word_0: got %h expected %h", rx_q[0], w0); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (rx_q[i+1] !== burst[i]) begin errors++; $display("FAIL order_word_%0d: got %h expected %h", i + 1, rx_q[i+1], burst[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int n, pulses0;
    rx_q.delete();
    pulses0 = m_latch_pulses;
    word = 32'hA5A5_F00F; valid = 1'b1;
    tick();
    word = 32'h0F0F_1234;
    tick();
    valid = 1'b0;
    n = 0;
    while (m_nbits != 10 && n < 1000) begin tick(); n++; end
    checks++; if (m_nbits != 10) begin errors++; $display("FAIL midreset_reach_bit10: got %0d expected 10", m_nbits); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL midreset_sclk_high: got %b expected 1", sclk); end
    rst = 1'b1;
    tick();
    checks++; if ({sclk, sdata, latch} !== 3'b000) begin errors++; $display("FAIL midreset_spi_outputs: got %b expected 000", {sclk, sdata, latch}); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_queue_emptied: busy got %b expected 0", busy); end
    checks++; if (m_latch_pulses != pulses0) begin errors++; $display("FAIL midreset_no_latch: got %0d pulses expected %0d", m_latch_pulses, pulses0); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midreset_no_word: got %0d expected 0", rx_q.size()); end
  endtask

  task automatic test_fast_timing();
    logic [31:0] fw0, fw1;
    fw0 = 32'hC3C3_0001;
    fw1 = 32'h9000_00FF;
    f_rx_q.delete();
    f_word = fw0; f_valid = 1'b1;
    tick();
    f_word = fw1;
    tick();
    f_valid = 1'b0;
    checks++; if (f_sdata !== 1'b1) begin errors++; $display("FAIL fast_load_data: got %b expected 1", f_sdata); end
    for (int k = 1; k <= 134; k++) begin
      tick();
      if (k == 64) begin
        checks++; if (f_sclk !== 1'b1) begin errors++; $display("FAIL fast_last_high: got %b expected 1", f_sclk); end
      end
      if (k == 65) begin
        checks++; if ({f_sclk, f_latch} !== 2'b01) begin errors++; $display("FAIL fast_latch1: sclk/latch got %b expected 01", {f_sclk, f_latch}); end
      end
      if (k == 66) begin
        checks++; if ({f_sclk, f_sdata, f_latch} !== 3'b000) begin errors++; $display("FAIL fast_gap: got %b expected 000", {f_sclk, f_sdata, f_latch}); end
      end
      if (k == 67) begin
        checks++; if ({f_sclk, f_sdata, f_latch} !== 3'b010) begin errors++; $display("FAIL fast_load2: got %b expected 010", {f_sclk, f_sdata, f_latch}); end
      end
      if (k == 132) begin
        checks++; if (f_latch !== 1'b1) begin errors++; $display("FAIL fast_latch2: got %b expected 1", f_latch); end
      end
      if (k == 133) begin
        checks++; if ({f_busy, f_latch} !== 2'b10) begin errors++; $display("FAIL fast_gap2: busy/latch got %b expected 10", {f_busy, f_latch}); end
      end
      if (k == 134) begin
        checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL fast_idle: busy got %b expected 0", f_busy); end
      end
    end
    checks++; if (f_rx_q.size() != 2) begin errors++; $display("FAIL fast_word_count: got %0d expected 2", f_rx_q.size()); end
    if (f_rx_q.size() == 2) begin
      checks++; if (f_rx_q[0] !== fw0) begin errors++; $display("FAIL fast_word0: got %h expected %h", f_rx_q[0], fw0); end
      checks++; if (f_rx_q[1] !== fw1) begin errors++; $display("FAIL fast_word1: got %h expected %h", f_rx_q[1], fw1); end
    end
  endtask

  task automatic test_monitor();
    checks++; if (m_viol != 0) begin errors++; $display("FAIL monitor_default: got %0d violations expected 0", m_viol); end
    checks++; if (fm_viol != 0) begin errors++; $display("FAIL monitor_fast: got %0d violations expected 0", fm_viol); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid_word();
    test_fast_timing();
    test_monitor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
